// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM state, accumulator width and saturation bounds for the neuron datapath
package nn_pkg;
  typedef enum logic [2:0] {IDLE, REQ, CAP, BIAS, OUT} state_t;
  function automatic int acc_w(input int in_w, input int w_w, input int n_in);
    return in_w + w_w + $clog2(n_in + 1);
  endfunction
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/nn_sat_act.sv
// nn_sat_act: shift by FRAC, saturate to OUT_W, then activate (ReLU when NN_NEURON_RELU_EN is defined)
module nn_sat_act import nn_pkg::*; #(
  parameter int ACC_W = 38,
  parameter int OUT_W = 28,
  parameter int FRAC = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y
);
  localparam logic signed [63:0] HI = sat_max(OUT_W);
  localparam logic signed [63:0] LO = sat_min(OUT_W);
  logic signed [ACC_W-1:0] sh;
  logic signed [63:0] sx;
  logic signed [OUT_W-1:0] sat;
  always_comb begin
    sh = acc >>> FRAC;
    sx = 64'(sh);
    sat = sx > HI ? OUT_W'(HI) : sx < LO ? OUT_W'(LO) : OUT_W'(sx);
`ifdef NN_NEURON_RELU_EN
    y = sat[OUT_W-1] ? '0 : sat;
`else
    y = sat;
`endif
  end
endmodule

// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac: streaming MAC neuron with writable weights/bias; NN_NEURON_RELU_EN selects ReLU output
module nn_neuron_mac import nn_pkg::*; #(
  parameter int IN_W = 19,
  parameter int W_W = 16,
  parameter int OUT_W = 28,
  parameter int N_IN = 4,
  parameter int FRAC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic signed [IN_W-1:0] in,
  input  logic wr_en,
  input  logic [$clog2(N_IN+1)-1:0] wr_addr,
  input  logic signed [W_W-1:0] wr_data,
  output logic in_req,
  output logic signed [OUT_W-1:0] io_out,
  output logic out_en,
  output logic busy
);
  localparam int ACC_W = acc_w(IN_W, W_W, N_IN);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int AW = $clog2(N_IN + 1);
  localparam int PW = IN_W + W_W;
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic signed [ACC_W-1:0] acc, acc_b;
  logic signed [PW-1:0] prod;
  logic signed [W_W-1:0] w [N_IN];
  logic signed [W_W-1:0] bias;
  logic signed [OUT_W-1:0] y;
  logic last;
  assign last = idx == IW'(N_IN - 1);
  assign prod = PW'(in) * PW'(w[idx]);
  assign acc_b = acc + ACC_W'(bias);
  nn_sat_act #(.ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_sat (.acc(acc_b), .y(y));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = en ? REQ : IDLE;
      REQ: nxt = CAP;
      CAP: nxt = last ? BIAS : REQ;
      BIAS: nxt = OUT;
      OUT: nxt = en ? REQ : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_req = state == REQ;
    out_en = state == OUT;
    busy = state != IDLE;
  end
  // io_out loads on the edge into OUT so it is already valid while out_en is high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      idx <= '0;
      io_out <= '0;
    end else begin
      if (state == IDLE || state == OUT) begin
        acc <= '0;
        idx <= '0;
      end
      if (state == CAP) begin
        acc <= acc + ACC_W'(prod);
        idx <= last ? idx : idx + 1'b1;
      end
      if (state == BIAS) begin
        acc <= acc_b;
        io_out <= y;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
      bias <= '0;
    end else if (wr_en && state == IDLE) begin
      if (wr_addr == BIAS_ADDR) bias <= wr_data;
      else if (wr_addr < BIAS_ADDR) w[IW'(wr_addr)] <= wr_data;
    end
endmodule

// File: tb/tb_nn_neuron_mac.sv
// tb_nn_neuron_mac: scoreboard bench driving a wide-output and an 8-bit-output neuron with shared stimulus
module tb_nn_neuron_mac;
  logic clk = 0, rst = 0, en = 0, wr_en = 0;
  logic signed [18:0] din = '0;
  logic [2:0] wr_addr = '0;
  logic signed [15:0] wr_data = '0;
  logic in_req0, oe0, busy0, in_req1, oe1, busy1;
  logic signed [27:0] io0;
  logic signed [7:0] io1;
  int q0[$], q1[$], sq[$];
  int tests = 0, fails = 0, cyc = 0, e0x, e1x;
  bit prev0 = 0, prev1 = 0;
`ifdef NN_NEURON_RELU_EN
  localparam bit RELU = 1;
`else
  localparam bit RELU = 0;
`endif
  nn_neuron_mac #(.IN_W(19), .W_W(16), .OUT_W(28), .N_IN(4), .FRAC(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .in(din), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_req(in_req0), .io_out(io0), .out_en(oe0), .busy(busy0));
  nn_neuron_mac #(.IN_W(19), .W_W(16), .OUT_W(8), .N_IN(4), .FRAC(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .in(din), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_req(in_req1), .io_out(io1), .out_en(oe1), .busy(busy1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic int act(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction
  always @(negedge clk) if (in_req0) din = sq.size() != 0 ? 19'(sq.pop_front()) : '0;
  always @(negedge clk) begin
    if (rst) begin
      if (oe0) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL out0 unexpected strobe io_out=%0d", io0);
        end else begin
          e0x = q0.pop_front();
          if (io0 !== e0x) begin
            fails++;
            $display("FAIL out0 io_out=%0d expected %0d", io0, e0x);
          end
        end
        tests++;
        if (in_req0 || prev0) begin
          fails++;
          $display("FAIL out0 strobe shape in_req=%0b prev_out_en=%0b expected 0/0", in_req0, prev0);
        end
      end
      if (oe1) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL out1 unexpected strobe io_out=%0d", io1);
        end else begin
          e1x = q1.pop_front();
          if (io1 !== e1x) begin
            fails++;
            $display("FAIL out1 io_out=%0d expected %0d", io1, e1x);
          end
        end
      end
    end
    prev0 = oe0;
    prev1 = oe1;
  end
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic wr(input int a, input int d);
    wr_addr = 3'(a);
    wr_data = 16'(d);
    wr_en = 1;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic setw(input int wv, input int b);
    for (int i = 0; i < 4; i++) wr(i, wv);
    wr(4, b);
  endtask
  task automatic frame(input int a, input int b, input int c, input int d, input int e0, input int e1);
    sq.push_back(a); sq.push_back(b); sq.push_back(c); sq.push_back(d);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask
  task automatic run(input int n, input bit wr_mid);
    int reqs = 0, outs = 0, t0 = 0, last = 0;
    en = 1;
    for (int c = 0; c < 40 * n && outs < n; c++) begin
      @(negedge clk);
      if (in_req0) begin
        reqs++;
        if (reqs == 1) t0 = cyc;
        if (reqs == 4 * (n - 1) + 1) en = 0;
      end
      if (oe0) begin
        outs++;
        if (outs == 1) chk("latency", cyc - t0, 9);
        else chk("period", cyc - last, 10);
        last = cyc;
      end
      if (wr_mid) begin
        wr_en = busy0 && outs < n;
        wr_addr = '0;
        wr_data = '0;
      end
    end
    en = 0;
    wr_en = 0;
    if (outs != n) begin
      tests++;
      fails++;
      $display("FAIL frame timeout strobes %0d expected %0d", outs, n);
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst in_req", in_req0, 0);
    chk("rst out_en", oe0, 0);
    chk("rst busy", busy0, 0);
    chk("rst io_out", io0, 0);
    chk("rst busy1", busy1, 0);
    chk("rst io_out1", io1, 0);
    rst = 1;
    @(negedge clk);
    setw(16, 0);
    frame(1, 2, 3, 4, 10, 10);
    run(1, 0);
    wr(4, 32);
    frame(1, 2, 3, 4, 12, 12);
    run(1, 0);
    setw(-16, 0);
    frame(1, 2, 3, 4, act(-10), act(-10));
    run(1, 0);
    setw(32, 0);
    frame(100, 100, 100, 100, 800, 127);
    frame(-100, -100, -100, -100, act(-800), act(-128));
    run(2, 0);
    setw(16, 0);
    frame(1, 2, 3, 4, 10, 10);
    frame(4, 3, 2, 1, 10, 10);
    frame(5, 5, 5, 5, 20, 20);
    run(3, 1);
    setw(1, 0);
    wr(7, 100);
    frame(0, 0, 0, 17, 1, 1);
    frame(-1, 0, 0, 0, act(-1), act(-1));
    run(2, 0);
    en = 1;
    c = 0;
    while (!in_req0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t7 reached req", in_req0, 1);
    @(negedge clk);
    chk("t7 in cap busy", busy0, 1);
    #2 rst = 0;
    #1;
    chk("async rst in_req", in_req0, 0);
    chk("async rst out_en", oe0, 0);
    chk("async rst busy", busy0, 0);
    chk("async rst io_out", io0, 0);
    chk("async rst busy1", busy1, 0);
    sq.delete();
    frame(16, 32, 48, 64, 0, 0);
    @(negedge clk);
    rst = 1;
    run(1, 0);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
